unidade_busca: RTL

Instruction fetch unit that drives the program ROM's read address and delivers each fetched 8-bit instruction to the decode/execute stage. It owns the program counter (PC), registers the ROM's combinational output into an instruction register, and offers it over a valid/ready handshake. It accepts redirect requests from the execute stage for taken JMP and BEQ, flushing the wrong-path instruction. It sits between the ROM and the control unit.

---
 rtl/unidade_busca.sv | 132 +++++++++++++
 1 files changed

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// Module      : unidade_busca
// Description : Instruction fetch unit. Owns the program counter, drives the
//               ROM read address, registers the fetched instruction and
//               offers it to the decode stage over a valid/ready handshake.
//               Taken branches (desvio) re-target the PC and flush the
//               wrong-path instruction with a single bubble cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_busca #(
  parameter int LARGURA_END   = 8,
  parameter int LARGURA_INSTR = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilita,
  output logic [LARGURA_END-1:0]   ler_endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao_in,
  output logic [LARGURA_INSTR-1:0] instrucao_out,
  output logic [LARGURA_END-1:0]   pc_out,
  output logic                     valido,
  input  logic                     pronto,
  input  logic                     desvio,
  input  logic [LARGURA_END-1:0]   alvo_desvio,
  output logic [1:0]               estado,
  output logic [15:0]              contador_instr
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    BUSCANDO = 2'd1,
    DESVIO   = 2'd2
  } estado_t;

  estado_t                  r_estado;
  estado_t                  w_prox_estado;
  logic [LARGURA_END-1:0]   r_pc;
  logic [LARGURA_END-1:0]   r_pc_out;
  logic [LARGURA_INSTR-1:0] r_ir;
  logic                     r_valido;
  logic [15:0]              r_contador;

  logic w_slot_livre;
  logic w_transfer;
  logic w_captura;

  assign w_slot_livre = !r_valido || pronto;
  assign w_transfer   = r_valido && pronto;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state and capture decision; a redirect overrides everything else.
  // Leaving DESVIO with habilita high captures the target instruction on the
  // same edge, so the redirect costs exactly one bubble.
  always_comb begin
    w_prox_estado = r_estado;
    w_captura     = 1'b0;
    if (desvio) begin
      w_prox_estado = DESVIO;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (habilita) begin
            w_prox_estado = BUSCANDO;
          end
        end
        BUSCANDO: begin
          if (!habilita) begin
            w_prox_estado = OCIOSO;
          end else begin
            w_captura = w_slot_livre;
          end
        end
        DESVIO: begin
          if (habilita) begin
            w_prox_estado = BUSCANDO;
            w_captura     = 1'b1;
          end else begin
            w_prox_estado = OCIOSO;
          end
        end
        default: begin
          w_prox_estado = OCIOSO;
        end
      endcase
    end
  end

  // PC, instruction register, valid flag and transfer counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_pc_out   <= '0;
      r_ir       <= '0;
      r_valido   <= 1'b0;
      r_contador <= 16'd0;
    end else begin
      // A transfer on a redirect edge still counts; the IR is flushed after.
      if (w_transfer) begin
        r_contador <= r_contador + 16'd1;
      end
      if (desvio) begin
        r_pc     <= alvo_desvio;
        r_valido <= 1'b0;
      end else if (w_captura) begin
        r_ir     <= instrucao_in;
        r_pc_out <= r_pc;
        r_valido <= 1'b1;
        r_pc     <= r_pc + LARGURA_END'(1);
      end else if (w_transfer) begin
        r_valido <= 1'b0;
      end
    end
  end

  assign ler_endereco   = r_pc;
  assign instrucao_out  = r_ir;
  assign pc_out         = r_pc_out;
  assign valido         = r_valido;
  assign estado         = r_estado;
  assign contador_instr = r_contador;

endmodule
`default_nettype wire
